// File: rtl/core_top_pkg.sv
// Shared constants, types and helpers for the core_top integration slice.
package core_top_pkg;

    localparam int          RAM_ADDR_WIDTH_DEF = 16;
    localparam logic [31:0] BOOT_ADDR_DEF      = 32'h0000_0000;
    localparam logic [31:0] RESET_VEC_OFFSET   = 32'h0000_0080;

    // Execution phases of the compact core: fetch, wait for the word, and a data access.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_WAIT_I = 3'd2,
        S_MEM    = 3'd3,
        S_WAIT_D = 3'd4
    } core_state_e;

    // Sign-extend a 12-bit immediate to 32 bits.
    function automatic logic [31:0] sext12(input logic [11:0] imm);
        return {{20{imm[11]}}, imm};
    endfunction

endpackage

// File: rtl/core_ram.sv
// Single-cycle memory subsystem: always-granted instruction and data ports over dp_ram.
module core_ram import core_top_pkg::*; #(
    parameter int RAM_ADDR_WIDTH = RAM_ADDR_WIDTH_DEF
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    input  logic        data_req_i,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o
);

    logic instr_rvalid_q, instr_rvalid_d;
    logic data_rvalid_q, data_rvalid_d;
    logic unused_s;

    // Upper address bits alias the RAM; the byte offset is replaced by the byte enables.
    assign unused_s = ^{instr_addr_i[31:RAM_ADDR_WIDTH], instr_addr_i[1:0],
                        data_addr_i[31:RAM_ADDR_WIDTH], data_addr_i[1:0]};

    assign instr_gnt_o = instr_req_i;
    assign data_gnt_o  = data_req_i;

    // Every granted request returns exactly one rvalid on the following cycle.
    always_comb begin
        instr_rvalid_d = instr_req_i;
        data_rvalid_d  = data_req_i;
    end

    // Response-valid flops; reset drops any response still in flight.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            instr_rvalid_q <= 1'b0;
            data_rvalid_q  <= 1'b0;
        end else begin
            instr_rvalid_q <= instr_rvalid_d;
            data_rvalid_q  <= data_rvalid_d;
        end
    end

    assign instr_rvalid_o = instr_rvalid_q;
    assign data_rvalid_o  = data_rvalid_q;

    dp_ram #(.ADDR_WIDTH(RAM_ADDR_WIDTH)) dp_ram_i (
        .clk_i     (clk_i),
        .en_a_i    (instr_req_i),
        .addr_a_i  (instr_addr_i[RAM_ADDR_WIDTH-1:2]),
        .rdata_a_o (instr_rdata_o),
        .en_b_i    (data_req_i),
        .addr_b_i  (data_addr_i[RAM_ADDR_WIDTH-1:2]),
        .we_b_i    (data_we_i),
        .be_b_i    (data_be_i),
        .wdata_b_i (data_wdata_i),
        .rdata_b_o (data_rdata_o)
    );

endmodule

// File: rtl/dp_ram.sv
// Word-organised dual-port RAM: port A read-only, port B byte-writable, read-first.
module dp_ram #(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  en_a_i,
    input  logic [ADDR_WIDTH-3:0] addr_a_i,
    output logic [31:0]           rdata_a_o,
    input  logic                  en_b_i,
    input  logic [ADDR_WIDTH-3:0] addr_b_i,
    input  logic                  we_b_i,
    input  logic [3:0]            be_b_i,
    input  logic [31:0]           wdata_b_i,
    output logic [31:0]           rdata_b_o
);

    logic [31:0] mem [2**(ADDR_WIDTH-2)];
    logic [31:0] rdata_a_q;
    logic [31:0] rdata_b_q;

    // Port A read: the registered word is the value before any same-edge write.
    always_ff @(posedge clk_i) begin
        if (en_a_i) begin
            rdata_a_q <= mem[addr_a_i];
        end
    end

    // Port B read-first access with per-lane byte writes; contents are never reset.
    always_ff @(posedge clk_i) begin
        if (en_b_i) begin
            rdata_b_q <= mem[addr_b_i];
            if (we_b_i) begin
                for (int i = 0; i < 4; i++) begin
                    if (be_b_i[i]) begin
                        mem[addr_b_i][8*i +: 8] <= wdata_b_i[8*i +: 8];
                    end
                end
            end
        end
    end

    assign rdata_a_o = rdata_a_q;
    assign rdata_b_o = rdata_b_q;

endmodule

// File: rtl/riscv_core.sv
// Compact RV32I-subset core exposing the RI5CY pin interface (OP-IMM, LUI, JAL,
// BEQ/BNE, LW, SB/SH/SW, CSRRSI/CSRRCI on mstatus.MIE, vectored interrupts).
module riscv_core import core_top_pkg::*; (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clock_en_i,
    input  logic        test_en_i,
    input  logic [31:0] boot_addr_i,
    input  logic [3:0]  core_id_i,
    input  logic [5:0]  cluster_id_i,
    output logic        instr_req_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    output logic [31:0] instr_addr_o,
    input  logic [31:0] instr_rdata_i,
    output logic        data_req_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic [31:0] data_rdata_i,
    input  logic        data_err_i,
    input  logic        irq_i,
    input  logic [4:0]  irq_id_i,
    output logic        irq_ack_o,
    output logic [4:0]  irq_id_o,
    input  logic        irq_sec_i,
    output logic        sec_lvl_o,
    input  logic        debug_req_i,
    output logic        debug_gnt_o,
    output logic        debug_rvalid_o,
    input  logic [14:0] debug_addr_i,
    input  logic        debug_we_i,
    input  logic [31:0] debug_wdata_i,
    output logic [31:0] debug_rdata_o,
    input  logic        fetch_enable_i,
    output logic        core_busy_o
);

    core_state_e state_q, state_d;
    logic [31:0] pc_q, pc_d, maddr_q, maddr_d, mwdata_q, mwdata_d;
    logic [3:0]  mbe_q, mbe_d;
    logic        mwe_q, mwe_d, mie_q, mie_d, ack_q, ack_d, busy_q, busy_d;
    logic [4:0]  mrd_q, mrd_d, irq_id_q, irq_id_d;
    logic        dbg_gnt_q, dbg_gnt_d, dbg_rvalid_q, dbg_rvalid_d, sec_lvl_q;
    logic [31:0] dbg_rdata_q, dbg_rdata_d;
    logic [31:0] rf_q [32];
    logic        rf_we_s, instr_req_s, data_req_s;
    logic [4:0]  rf_waddr_s;
    logic [31:0] rf_wdata_s, ir_s, rs1v_s, rs2v_s, imm_b_s, imm_j_s, sum_i_s, st_addr_s;
    logic        unused_s;

    assign unused_s = ^{clock_en_i, test_en_i, core_id_i, cluster_id_i, data_err_i,
                        irq_sec_i, debug_addr_i, debug_wdata_i, maddr_q[1:0]};

    assign ir_s      = instr_rdata_i;
    assign rs1v_s    = (ir_s[19:15] == 5'd0) ? 32'd0 : rf_q[ir_s[19:15]];
    assign rs2v_s    = (ir_s[24:20] == 5'd0) ? 32'd0 : rf_q[ir_s[24:20]];
    assign imm_b_s   = {{20{ir_s[31]}}, ir_s[7], ir_s[30:25], ir_s[11:8], 1'b0};
    assign imm_j_s   = {{12{ir_s[31]}}, ir_s[19:12], ir_s[20], ir_s[30:21], 1'b0};
    assign sum_i_s   = rs1v_s + sext12(ir_s[31:20]);
    assign st_addr_s = rs1v_s + sext12({ir_s[31:25], ir_s[11:7]});

    // Next-state, execute and bus-request logic; one instruction completes per pass.
    always_comb begin
        state_d = state_q;  pc_d = pc_q;  mie_d = mie_q;  busy_d = busy_q;
        maddr_d = maddr_q;  mwdata_d = mwdata_q;  mbe_d = mbe_q;  mwe_d = mwe_q;
        mrd_d = mrd_q;  ack_d = 1'b0;  irq_id_d = irq_id_q;
        rf_we_s = 1'b0;  rf_waddr_s = ir_s[11:7];  rf_wdata_s = 32'd0;
        instr_req_s = 1'b0;  data_req_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (fetch_enable_i) begin
                    state_d = S_FETCH;
                    busy_d  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                if (irq_i && mie_q) begin
                    // Vector to boot_addr + 4*id and mask further interrupts.
                    ack_d    = 1'b1;
                    irq_id_d = irq_id_i;
                    mie_d    = 1'b0;
                    pc_d     = {boot_addr_i[31:8], 8'h00} + {25'd0, irq_id_i, 2'b00};
                end else begin
                    instr_req_s = 1'b1;
                    state_d     = instr_gnt_i ? S_WAIT_I : S_FETCH;
                end
            end
            S_WAIT_I: begin
                if (instr_rvalid_i) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = S_FETCH;
                    case (ir_s[6:0])
                        7'b0010011: begin
                            rf_we_s = 1'b1;
                            case (ir_s[14:12])
                                3'b100:  rf_wdata_s = rs1v_s ^ sext12(ir_s[31:20]);
                                3'b110:  rf_wdata_s = rs1v_s | sext12(ir_s[31:20]);
                                3'b111:  rf_wdata_s = rs1v_s & sext12(ir_s[31:20]);
                                default: rf_wdata_s = sum_i_s;
                            endcase
                        end
                        7'b0110111: begin
                            rf_we_s    = 1'b1;
                            rf_wdata_s = {ir_s[31:12], 12'h000};
                        end
                        7'b1101111: begin
                            rf_we_s    = 1'b1;
                            rf_wdata_s = pc_q + 32'd4;
                            pc_d       = pc_q + imm_j_s;
                        end
                        7'b1100011: begin
                            if ((ir_s[12] == 1'b0) == (rs1v_s == rs2v_s)) begin
                                pc_d = pc_q + imm_b_s;
                            end else begin
                                pc_d = pc_q + 32'd4;
                            end
                        end
                        7'b0100011: begin
                            state_d = S_MEM;
                            maddr_d = st_addr_s;
                            mwe_d   = 1'b1;
                            case (ir_s[13:12])
                                2'b00: begin
                                    mbe_d    = 4'b0001 << st_addr_s[1:0];
                                    mwdata_d = {4{rs2v_s[7:0]}};
                                end
                                2'b01: begin
                                    mbe_d    = 4'b0011 << {st_addr_s[1], 1'b0};
                                    mwdata_d = {2{rs2v_s[15:0]}};
                                end
                                default: begin
                                    mbe_d    = 4'b1111;
                                    mwdata_d = rs2v_s;
                                end
                            endcase
                        end
                        7'b0000011: begin
                            state_d = S_MEM;
                            maddr_d = sum_i_s;
                            mwe_d   = 1'b0;
                            mbe_d   = 4'b1111;
                            mrd_d   = ir_s[11:7];
                        end
                        7'b1110011: begin
                            if (ir_s[31:20] == 12'h300 && ir_s[18]) begin
                                mie_d = (ir_s[13:12] == 2'b10);
                            end else begin
                                mie_d = mie_q;
                            end
                        end
                        default: pc_d = pc_q + 32'd4;
                    endcase
                end else begin
                    state_d = S_WAIT_I;
                end
            end
            S_MEM: begin
                data_req_s = 1'b1;
                state_d    = data_gnt_i ? S_WAIT_D : S_MEM;
            end
            S_WAIT_D: begin
                if (data_rvalid_i) begin
                    state_d    = S_FETCH;
                    rf_we_s    = !mwe_q;
                    rf_waddr_s = mrd_q;
                    rf_wdata_s = data_rdata_i;
                end else begin
                    state_d = S_WAIT_D;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Minimal debug responder: one-cycle grant, read data (current PC) one cycle later.
    always_comb begin
        dbg_gnt_d    = debug_req_i & ~dbg_gnt_q;
        dbg_rvalid_d = dbg_gnt_q;
        if (dbg_gnt_q && !debug_we_i) begin
            dbg_rdata_d = pc_q;
        end else begin
            dbg_rdata_d = dbg_rdata_q;
        end
    end

    // Core state, PC, pending data access and registered status outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;  pc_q <= boot_addr_i + RESET_VEC_OFFSET;
            maddr_q <= 32'd0;  mwdata_q <= 32'd0;  mbe_q <= 4'd0;  mwe_q <= 1'b0;
            mrd_q <= 5'd0;  mie_q <= 1'b0;  ack_q <= 1'b0;  irq_id_q <= 5'd0;
            busy_q <= 1'b0;  dbg_gnt_q <= 1'b0;  dbg_rvalid_q <= 1'b0;
            dbg_rdata_q <= 32'd0;  sec_lvl_q <= 1'b1;
        end else begin
            state_q <= state_d;  pc_q <= pc_d;
            maddr_q <= maddr_d;  mwdata_q <= mwdata_d;  mbe_q <= mbe_d;  mwe_q <= mwe_d;
            mrd_q <= mrd_d;  mie_q <= mie_d;  ack_q <= ack_d;  irq_id_q <= irq_id_d;
            busy_q <= busy_d;  dbg_gnt_q <= dbg_gnt_d;  dbg_rvalid_q <= dbg_rvalid_d;
            dbg_rdata_q <= dbg_rdata_d;  sec_lvl_q <= 1'b1;
        end
    end

    // Register file; x0 is never written and always reads as zero.
    always_ff @(posedge clk_i) begin
        if (rf_we_s && rf_waddr_s != 5'd0) begin
            rf_q[rf_waddr_s] <= rf_wdata_s;
        end
    end

    assign instr_req_o    = instr_req_s;
    assign instr_addr_o   = pc_q;
    assign data_req_o     = data_req_s;
    assign data_we_o      = mwe_q;
    assign data_be_o      = mbe_q;
    assign data_addr_o    = {maddr_q[31:2], 2'b00};
    assign data_wdata_o   = mwdata_q;
    assign irq_ack_o      = ack_q;
    assign irq_id_o       = irq_id_q;
    assign sec_lvl_o      = sec_lvl_q;
    assign debug_gnt_o    = dbg_gnt_q;
    assign debug_rvalid_o = dbg_rvalid_q;
    assign debug_rdata_o  = dbg_rdata_q;
    assign core_busy_o    = busy_q;

endmodule

// File: rtl/core_top.sv
// Simulation/prototyping top: riscv_core with one dual-port RAM for code and data.
module core_top import core_top_pkg::*; #(
    parameter int          RAM_ADDR_WIDTH = RAM_ADDR_WIDTH_DEF,
    parameter logic [31:0] BOOT_ADDR      = BOOT_ADDR_DEF
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        irq_i,
    input  logic [4:0]  irq_id_i,
    output logic        irq_ack_o,
    output logic [4:0]  irq_id_o,
    input  logic        irq_sec_i,
    output logic        sec_lvl_o,
    input  logic        debug_req_i,
    output logic        debug_gnt_o,
    output logic        debug_rvalid_o,
    input  logic [14:0] debug_addr_i,
    input  logic        debug_we_i,
    input  logic [31:0] debug_wdata_i,
    output logic [31:0] debug_rdata_o,
    input  logic        fetch_enable_i,
    output logic        core_busy_o
);

    logic        instr_req_s, instr_gnt_s, instr_rvalid_s;
    logic [31:0] instr_addr_s, instr_rdata_s;
    logic        data_req_s, data_gnt_s, data_rvalid_s, data_we_s;
    logic [3:0]  data_be_s;
    logic [31:0] data_addr_s, data_wdata_s, data_rdata_s;

    riscv_core core_i (
        .clk_i (clk_i), .rst_ni (rstn_i),
        .clock_en_i (1'b1), .test_en_i (1'b0), .boot_addr_i (BOOT_ADDR),
        .core_id_i (4'd0), .cluster_id_i (6'd0),
        .instr_req_o (instr_req_s), .instr_gnt_i (instr_gnt_s),
        .instr_rvalid_i (instr_rvalid_s), .instr_addr_o (instr_addr_s),
        .instr_rdata_i (instr_rdata_s),
        .data_req_o (data_req_s), .data_gnt_i (data_gnt_s), .data_rvalid_i (data_rvalid_s),
        .data_we_o (data_we_s), .data_be_o (data_be_s), .data_addr_o (data_addr_s),
        .data_wdata_o (data_wdata_s), .data_rdata_i (data_rdata_s), .data_err_i (1'b0),
        .irq_i (irq_i), .irq_id_i (irq_id_i), .irq_ack_o (irq_ack_o), .irq_id_o (irq_id_o),
        .irq_sec_i (irq_sec_i), .sec_lvl_o (sec_lvl_o),
        .debug_req_i (debug_req_i), .debug_gnt_o (debug_gnt_o),
        .debug_rvalid_o (debug_rvalid_o), .debug_addr_i (debug_addr_i),
        .debug_we_i (debug_we_i), .debug_wdata_i (debug_wdata_i),
        .debug_rdata_o (debug_rdata_o),
        .fetch_enable_i (fetch_enable_i), .core_busy_o (core_busy_o)
    );

    core_ram #(.RAM_ADDR_WIDTH(RAM_ADDR_WIDTH)) ram_i (
        .clk_i (clk_i), .rstn_i (rstn_i),
        .instr_req_i (instr_req_s), .instr_addr_i (instr_addr_s),
        .instr_gnt_o (instr_gnt_s), .instr_rvalid_o (instr_rvalid_s),
        .instr_rdata_o (instr_rdata_s),
        .data_req_i (data_req_s), .data_addr_i (data_addr_s), .data_we_i (data_we_s),
        .data_be_i (data_be_s), .data_wdata_i (data_wdata_s),
        .data_gnt_o (data_gnt_s), .data_rvalid_o (data_rvalid_s),
        .data_rdata_o (data_rdata_s)
    );

endmodule

// File: tb/tb_core_top.sv
// Firmware-level bench for core_top: preloads the RAM, runs small programs with
// randomised store values/addresses and compares memory to a byte-level model.
module tb_core_top;

    logic        clk = 1'b0;
    logic        rstn;
    logic        irq, irq_sec, dbg_req, dbg_we, fe;
    logic [4:0]  irq_id;
    logic [14:0] dbg_addr;
    logic [31:0] dbg_wdata;
    logic        irq_ack, sec_lvl, dbg_gnt, dbg_rvalid, busy;
    logic [4:0]  irq_id_out;
    logic [31:0] dbg_rdata;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] exp_mem [int];
    logic [31:0] prog [$];

    localparam logic [31:0] J_SELF     = 32'h0000_006f;
    localparam logic [31:0] CSRRSI_MIE = {12'h300, 5'd8, 3'b110, 5'd0, 7'h73};

    always #5 clk = ~clk;

    core_top dut (
        .clk_i (clk), .rstn_i (rstn), .irq_i (irq), .irq_id_i (irq_id),
        .irq_ack_o (irq_ack), .irq_id_o (irq_id_out), .irq_sec_i (irq_sec),
        .sec_lvl_o (sec_lvl), .debug_req_i (dbg_req), .debug_gnt_o (dbg_gnt),
        .debug_rvalid_o (dbg_rvalid), .debug_addr_i (dbg_addr), .debug_we_i (dbg_we),
        .debug_wdata_i (dbg_wdata), .debug_rdata_o (dbg_rdata),
        .fetch_enable_i (fe), .core_busy_o (busy)
    );

    // Tiny assembler for the instructions the programs use.
    function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [4:0] rs1,
                                             input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'h13};
    endfunction
    function automatic logic [31:0] enc_lui(input logic [4:0] rd, input logic [19:0] imm);
        return {imm, rd, 7'h37};
    endfunction
    function automatic logic [31:0] enc_st(input logic [2:0] f3, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [11:0] imm);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference memory: byte-addressed stores, address taken modulo the 64 KiB RAM.
    task automatic model_store(input logic [31:0] addr, input logic [31:0] val, input int nbytes);
        for (int b = 0; b < nbytes; b++) begin
            int unsigned a, idx, lane;
            logic [31:0] w;
            a    = (addr + b) % 65536;
            idx  = a / 4;
            lane = a % 4;
            w    = exp_mem.exists(idx) ? exp_mem[idx] : 32'h0;
            w    = (w & ~(32'hFF << (8 * lane))) | (((val >> (8 * b)) & 32'hFF) << (8 * lane));
            exp_mem[idx] = w;
        end
    endtask

    task automatic preload(input logic [31:0] addr, input logic [31:0] w);
        dut.ram_i.dp_ram_i.mem[addr[15:2]] = w;
        exp_mem[int'(addr[15:2])] = w;
    endtask

    task automatic load_prog();
        foreach (prog[i]) dut.ram_i.dp_ram_i.mem[32 + i] = prog[i];
    endtask

    task automatic check_mem(input string tag);
        foreach (exp_mem[k]) chk($sformatf("%s_w%0h", tag, k), dut.ram_i.dp_ram_i.mem[k], exp_mem[k]);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_irq_ack"},  {31'd0, irq_ack},    32'd0);
        chk({tag, "_irq_id"},   {27'd0, irq_id_out}, 32'd0);
        chk({tag, "_dbg_gnt"},  {31'd0, dbg_gnt},    32'd0);
        chk({tag, "_dbg_rv"},   {31'd0, dbg_rvalid}, 32'd0);
        chk({tag, "_dbg_rd"},   dbg_rdata,           32'd0);
        chk({tag, "_busy"},     {31'd0, busy},       32'd0);
        chk({tag, "_sec_lvl"},  {31'd0, sec_lvl},    32'd1);
        chk({tag, "_i_rvalid"}, {31'd0, dut.ram_i.instr_rvalid_q}, 32'd0);
        chk({tag, "_d_rvalid"}, {31'd0, dut.ram_i.data_rvalid_q},  32'd0);
    endtask

    // Release reset (fetch enabled) and run until the final "j ." is fetched.
    task automatic run_prog(input string tag, input int budget, output logic [31:0] first_addr);
        logic [31:0] end_pc;
        bit found, seen;
        end_pc = 32'h80 + 32'(4 * (prog.size() - 1));
        found = 1'b0;  seen = 1'b0;  first_addr = 32'hFFFF_FFFF;
        @(negedge clk);
        rstn = 1'b1;  fe = 1'b1;
        for (int c = 0; c < budget && !found; c++) begin
            @(negedge clk);
            if (dut.instr_req_s) begin
                if (!seen) first_addr = dut.instr_addr_s;
                seen = 1'b1;
                if (dut.instr_addr_s == end_pc) found = 1'b1;
            end
        end
        chk({tag, "_reached_end"}, {31'd0, found}, 32'd1);
        repeat (4) @(negedge clk);
    endtask

    task automatic hold_reset();
        @(negedge clk);
        rstn = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        logic [31:0] first, v, off, pre;
        int req_cnt, lane;
        bit done, got_ack;
        logic [4:0] ack_id;

        rstn = 1'b0;  fe = 1'b0;  irq = 1'b0;  irq_id = 5'd0;  irq_sec = 1'b0;
        dbg_req = 1'b0;  dbg_we = 1'b0;  dbg_addr = 15'd0;  dbg_wdata = 32'd0;
        for (int i = 0; i < 16384; i++) dut.ram_i.dp_ram_i.mem[i] = 32'h0;
        repeat (3) @(negedge clk);
        check_reset("por");

        // Fetch held off, then the basic store program.
        prog = {enc_addi(5'd1, 5'd0, 12'd5), enc_st(3'b010, 5'd1, 5'd0, 12'h100), J_SELF};
        load_prog();
        @(negedge clk);
        rstn = 1'b1;
        req_cnt = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (dut.instr_req_s) req_cnt++;
        end
        chk("fe0_no_fetch", 32'(req_cnt), 32'd0);
        chk("fe0_mem_untouched", dut.ram_i.dp_ram_i.mem[16'h40], 32'h0);
        fe = 1'b1;
        first = 32'hFFFF_FFFF;
        for (int c = 0; c < 20 && first == 32'hFFFF_FFFF; c++) begin
            @(negedge clk);
            if (dut.instr_req_s) first = dut.instr_addr_s;
        end
        chk("first_fetch", first, 32'h80);
        model_store(32'h100, 32'd5, 4);
        done = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (dut.ram_i.dp_ram_i.mem[16'h40] === 32'h5) done = 1'b1;
        end
        chk("p1_store", dut.ram_i.dp_ram_i.mem[16'h40], 32'h5);
        chk("p1_busy", {31'd0, busy}, 32'd1);

        // Byte store over a known word, random word stores, random-lane byte store.
        hold_reset();
        preload(32'h100, 32'h1122_3344);
        prog = {enc_addi(5'd2, 5'd0, 12'h0AB), enc_st(3'b000, 5'd2, 5'd0, 12'h103)};
        model_store(32'h103, 32'hAB, 1);
        for (int k = 0; k < 4; k++) begin
            v   = 32'($urandom_range(0, 2047));
            off = 32'h200 + 32'(4 * $urandom_range(0, 127));
            prog.push_back(enc_addi(5'd1, 5'd0, v[11:0]));
            prog.push_back(enc_st(3'b010, 5'd1, 5'd0, off[11:0]));
            model_store(off, v, 4);
        end
        pre  = $urandom;
        lane = $urandom_range(0, 3);
        v    = 32'($urandom_range(0, 255));
        preload(32'h180, pre);
        off  = 32'h180 + 32'(lane);
        prog.push_back(enc_addi(5'd5, 5'd0, v[11:0]));
        prog.push_back(enc_st(3'b000, 5'd5, 5'd0, off[11:0]));
        model_store(off, v, 1);
        prog.push_back(J_SELF);
        load_prog();
        run_prog("p2", 400, first);
        chk("p2_first_fetch", first, 32'h80);
        chk("sb_0x103", dut.ram_i.dp_ram_i.mem[16'h40], 32'hAB22_3344);
        check_mem("p2");

        // Asynchronous reset landing on a pending instruction response.
        done = 1'b0;
        for (int c = 0; c < 10 && !done; c++) begin
            @(negedge clk);
            if (dut.instr_req_s) done = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("rvalid_pending", {31'd0, dut.ram_i.instr_rvalid_q}, 32'd1);
        #2 rstn = 1'b0;
        #1;
        chk("rvalid_dropped", {31'd0, dut.ram_i.instr_rvalid_q}, 32'd0);
        repeat (3) @(negedge clk);
        check_reset("mid");
        check_mem("mid_preserved");
        run_prog("restart", 400, first);
        chk("restart_first_fetch", first, 32'h80);
        check_mem("restart");

        // Upper address bits alias onto the 64 KiB RAM.
        hold_reset();
        v = 32'($urandom_range(1, 2047));
        prog = {enc_lui(5'd3, 20'h00010), enc_addi(5'd4, 5'd0, v[11:0]),
                enc_st(3'b010, 5'd4, 5'd3, 12'h100), J_SELF};
        model_store(32'h0001_0100, v, 4);
        load_prog();
        run_prog("alias", 400, first);
        chk("alias_word", dut.ram_i.dp_ram_i.mem[16'h40], v);
        check_mem("alias");

        // Interrupt enabled in firmware, then request id 11.
        hold_reset();
        dut.ram_i.dp_ram_i.mem[11] = J_SELF;
        prog = {CSRRSI_MIE, J_SELF};
        load_prog();
        run_prog("irq", 200, first);
        @(negedge clk);
        irq = 1'b1;  irq_id = 5'd11;
        got_ack = 1'b0;  ack_id = 5'd0;
        for (int c = 0; c < 20 && !got_ack; c++) begin
            @(negedge clk);
            if (irq_ack) begin
                got_ack = 1'b1;
                ack_id  = irq_id_out;
            end
        end
        irq = 1'b0;
        chk("irq_ack_seen", {31'd0, got_ack}, 32'd1);
        chk("irq_ack_id", {27'd0, ack_id}, 32'd11);
        @(negedge clk);
        chk("irq_ack_pulse", {31'd0, irq_ack}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/core_top.md
# core_top

Integration top for the RI5CY-class RISC-V core (`riscv_core`, existing in the codebase) with a single on-chip dual-port RAM holding code and data. The instruction port uses RAM port A, the data port uses RAM port B. Interrupt, debug, fetch-enable and status pins pass straight through to the core. This block is the simulation and prototyping top: benches preload the RAM by hierarchical path and run firmware from reset.

## Interface
- `RAM_ADDR_WIDTH`, default 16: byte-address bits of RAM, giving 64 KiB (16384 × 32-bit words).
- `BOOT_ADDR`, default 32'h0000_0000: core `boot_addr_i`. First fetch is at `BOOT_ADDR + 0x80`.
- Clocking (already decided): one clock; reset is asynchronous and active-low.
- `clk_i`  in  1  clock.
- `rstn_i`  in  1  asynchronous active-low reset.
- `irq_i`  in  1  interrupt request.
- `irq_id_i`  in  5  interrupt ID.
- `irq_ack_o`  out  1  interrupt acknowledge.
- `irq_id_o`  out  5  acknowledged ID.
- `irq_sec_i`  in  1  secure interrupt.
- `sec_lvl_o`  out  1  current privilege (1 = machine).
- `debug_req_i`  in  1  debug access request.
- `debug_gnt_o`  out  1  debug grant.
- `debug_rvalid_o`  out  1  debug read-data valid.
- `debug_addr_i`  in  15  debug register address.
- `debug_we_i`  in  1  debug write.
- `debug_wdata_i`  in  32  debug write data.
- `debug_rdata_o`  out  32  debug read data.
- `fetch_enable_i`  in  1  core may fetch when 1.
- `core_busy_o`  out  1  core not sleeping.

## Operation
- Core tie-offs:
  - `clock_en_i` = 1, `test_en_i` = 0.
  - `core_id_i` = 0, `cluster_id_i` = 0.
  - `data_err_i` = 0.
- The RAM is word-organized. Word index = address[RAM_ADDR_WIDTH-1:2]. Upper address bits are ignored, so addresses alias modulo RAM size.
- Instruction port (RAM port A) is read-only:
  - `instr_gnt_i` = `instr_req_o` (combinational, always granted).
  - `instr_rvalid_i` asserts one cycle after each granted request, with `instr_rdata_i` = the word.
- Data port (RAM port B):
  - `data_gnt_i` = `data_req_o`.
  - On a write, each byte lane i with `data_be_o[i]` = 1 is updated at the grant-cycle clock edge. Other lanes are unchanged.
  - `data_rvalid_i` asserts one cycle later for both reads and writes. Read data is the pre-write word.
- Same-word collision: port B write plus port A read in one cycle gives port A the old word, and the write commits.
- RAM contents are not reset. Uninitialized words are X in simulation.
- Debug, interrupt, `fetch_enable_i`, `core_busy_o` and `sec_lvl_o` connect directly to the same-named core pins.

## Timing
- Reset values while `rstn_i` = 0:
  - `irq_ack_o` = 0, `irq_id_o` = 0.
  - `debug_gnt_o` = 0, `debug_rvalid_o` = 0, `debug_rdata_o` = 0.
  - `core_busy_o` = 0.
  - `sec_lvl_o` = 1.
  - Both RAM rvalid flops = 0.
- Memory latency is fixed at one cycle: request in cycle n, rvalid/rdata in cycle n+1. Back-to-back requests are accepted every cycle with no stall.
- Reset asserted mid-access: the pending rvalid is dropped immediately. A write already clocked remains in memory.
- After reset release with `fetch_enable_i` = 1, the first `instr_req_o` targets `BOOT_ADDR + 0x80` within a few cycles.

## Structure
- Package `core_top_pkg`: `RAM_ADDR_WIDTH` default, `BOOT_ADDR` default, reset-vector offset 0x80.
- Sub-module `core_ram`, instance name `ram_i`:
  - Wraps `dp_ram` (instance `dp_ram_i`) and the two rvalid flops.
  - Memory array must be named `mem`, declared `logic [31:0] mem [2**(RAM_ADDR_WIDTH-2)]`.
  - Benches load it as `ram_i.dp_ram_i.mem` via `$readmemh`.
- Core instance `riscv_core`, named `core_i`.

## Test plan
- Preload a hex image with `addi x1,x0,5; sw x1,0x100(x0); j .` at 0x80. Release reset with `fetch_enable_i` = 1. Within 100 cycles → `mem[0x40]` == 32'h5 and `core_busy_o` = 1.
- Hold `fetch_enable_i` = 0 for 50 cycles after reset → no `instr_req_o`, memory untouched. Raise it → first fetch address is 0x80.
- Run a `sb` of 0xAB to 0x103 over a word preloaded with 32'h11223344 → word becomes 32'hAB223344.
- Store to 0x10100 with `RAM_ADDR_WIDTH` = 16 → aliases to `mem[0x40]`.
- Assert `rstn_i` low mid-program for 3 cycles → all outputs return to their reset values, and the program restarts at 0x80 with RAM contents preserved.
- Drive `irq_i` = 1, `irq_id_i` = 5'd11 with interrupts enabled in firmware → `irq_ack_o` pulses with `irq_id_o` = 11.
